// File: rtl/matmul_pkg.sv
// Shared types and widths for the matmul accelerator's APB initiator.
package matmul_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int BUS_WIDTH  = 64;
    localparam int ADDR_WIDTH = 32;
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0]  wdata;
        logic [STRB_WIDTH-1:0] strb;
    } apb_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_mst_state_e;

endpackage

// File: rtl/matmul_apb_cmd_fifo.sv
// Two-entry command queue in front of the APB initiator; a push while full is dropped.
module matmul_apb_cmd_fifo
    import matmul_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_push,
    input  apb_cmd_t i_data,
    input  logic     i_pop,
    output apb_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    apb_cmd_t   r_mem [2];
    logic       r_wrPtr;
    logic       r_rdPtr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    // Fullness is judged before the pop, so a pop never makes room for a same-cycle push.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_data  = r_mem[r_rdPtr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/matmul_apb_master.sv
// APB initiator for the matmul slave port: queued commands become SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout abort is built only when MATMUL_APB_TIMEOUT_EN is defined.
module matmul_apb_master
   import matmul_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256
)
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
   input  logic [STRB_WIDTH-1:0] cmd_strb_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  busy_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [BUS_WIDTH-1:0]  pwdata_o,
   output logic [STRB_WIDTH-1:0] pstrb_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   input  logic [BUS_WIDTH-1:0]  prdata_i
);

   apb_mst_state_e        r_state;
   logic                  r_rstDone;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [BUS_WIDTH-1:0]  r_pwdata;
   logic [STRB_WIDTH-1:0] r_pstrb;
   logic                  r_rspValid;
   logic [BUS_WIDTH-1:0]  r_rspRdata;
   logic                  r_rspErr;

   apb_cmd_t w_cmdIn;
   apb_cmd_t w_head;
   logic     w_fifoFull;
   logic     w_fifoEmpty;
   logic     w_cmdReady;
   logic     w_rspTake;
   logic     w_issue;

`ifdef MATMUL_APB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] r_toCnt;
`endif

   assign w_cmdIn.write = cmd_write_i;
   assign w_cmdIn.addr  = cmd_addr_i;
   assign w_cmdIn.wdata = cmd_wdata_i;
   assign w_cmdIn.strb  = cmd_strb_i;

   // cmd_ready stays low until the first edge after reset release.
   assign w_cmdReady = r_rstDone & ~w_fifoFull;
   assign w_rspTake  = r_rspValid & rsp_ready_i;
   assign w_issue    = (r_state == IDLE) & ~w_fifoEmpty & (~r_rspValid | rsp_ready_i);

   matmul_apb_cmd_fifo u_cmdFifo (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_push  (cmd_valid_i & w_cmdReady),
      .i_data  (w_cmdIn),
      .i_pop   (w_issue),
      .o_data  (w_head),
      .o_full  (w_fifoFull),
      .o_empty (w_fifoEmpty)
   );

   // Main transfer FSM: issue from the FIFO, run SETUP then ACCESS, and capture the response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_rstDone  <= 1'b0;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_pstrb    <= '0;
         r_rspValid <= 1'b0;
         r_rspRdata <= '0;
         r_rspErr   <= 1'b0;
`ifdef MATMUL_APB_TIMEOUT_EN
         r_toCnt    <= '0;
`endif
      end else begin
         r_rstDone <= 1'b1;
         if (w_rspTake) begin
            r_rspValid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_psel   <= 1'b1;
                  r_pwrite <= w_head.write;
                  r_paddr  <= w_head.addr;
                  r_pwdata <= w_head.wdata;
                  r_pstrb  <= w_head.write ? w_head.strb : '0;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
`ifdef MATMUL_APB_TIMEOUT_EN
               r_toCnt   <= '0;
`endif
            end
            ACCESS: begin
               if (pready_i) begin
                  r_psel     <= 1'b0;
                  r_penable  <= 1'b0;
                  r_rspValid <= 1'b1;
                  r_rspRdata <= r_pwrite ? '0 : prdata_i;
                  r_rspErr   <= pslverr_i;
                  r_state    <= IDLE;
               end
`ifdef MATMUL_APB_TIMEOUT_EN
               else if (r_toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  r_psel     <= 1'b0;
                  r_penable  <= 1'b0;
                  r_rspValid <= 1'b1;
                  r_rspRdata <= '0;
                  r_rspErr   <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_toCnt <= r_toCnt + TO_W'(1);
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o = w_cmdReady;
   assign busy_o      = (r_state != IDLE) | ~w_fifoEmpty;
   assign psel_o      = r_psel;
   assign penable_o   = r_penable;
   assign pwrite_o    = r_pwrite;
   assign paddr_o     = r_paddr;
   assign pwdata_o    = r_pwdata;
   assign pstrb_o     = r_pstrb;
   assign rsp_valid_o = r_rspValid;
   assign rsp_rdata_o = r_rspRdata;
   assign rsp_err_o   = r_rspErr;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master with a wait-state-programmable APB slave model.
// Define MATMUL_APB_TIMEOUT_EN to also exercise the ACCESS timeout (TIMEOUT_CYC=8).
module tb_matmul_apb_master;
   import matmul_pkg::*;

   logic                  clk_i = 1'b0;
   logic                  rst_ni = 1'b0;
   logic                  cmd_valid_i = 1'b0;
   logic                  cmd_ready_o;
   logic                  cmd_write_i = 1'b0;
   logic [ADDR_WIDTH-1:0] cmd_addr_i = '0;
   logic [BUS_WIDTH-1:0]  cmd_wdata_i = '0;
   logic [STRB_WIDTH-1:0] cmd_strb_i = '0;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i = 1'b0;
   logic [BUS_WIDTH-1:0]  rsp_rdata_o;
   logic                  rsp_err_o;
   logic                  busy_o;
   logic                  psel_o;
   logic                  penable_o;
   logic                  pwrite_o;
   logic [ADDR_WIDTH-1:0] paddr_o;
   logic [BUS_WIDTH-1:0]  pwdata_o;
   logic [STRB_WIDTH-1:0] pstrb_o;
   logic                  pready_i;
   logic                  pslverr_i;
   logic [BUS_WIDTH-1:0]  prdata_i;

   int checks = 0;
   int errors = 0;

   int                    waitStates = 0;
   logic                  slvErr = 1'b0;
   logic [BUS_WIDTH-1:0]  rdData = '0;
   int                    setupCnt = 0;
   int                    accessCnt = 0;
   logic                  addrStable = 1'b1;
   logic [ADDR_WIDTH-1:0] setupAddr = '0;
   logic [STRB_WIDTH-1:0] setupStrb = '0;
   logic                  setupWrite = 1'b0;

   always #5 clk_i = ~clk_i;

   matmul_apb_master #(.TIMEOUT_CYC(8)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .cmd_strb_i  (cmd_strb_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pwrite_o    (pwrite_o),
      .paddr_o     (paddr_o),
      .pwdata_o    (pwdata_o),
      .pstrb_o     (pstrb_o),
      .pready_i    (pready_i),
      .pslverr_i   (pslverr_i),
      .prdata_i    (prdata_i)
   );

   // Slave raises pready on ACCESS cycle number waitStates+1.
   assign pready_i  = psel_o & penable_o & (accessCnt > waitStates);
   assign pslverr_i = slvErr;
   assign prdata_i  = rdData;

   // Phase monitor: counts SETUP and ACCESS cycles and records transfer attributes.
   always @(negedge clk_i) begin
      if (psel_o && !penable_o) begin
         setupCnt   <= setupCnt + 1;
         accessCnt  <= 0;
         addrStable <= 1'b1;
         setupAddr  <= paddr_o;
         setupStrb  <= pstrb_o;
         setupWrite <= pwrite_o;
      end else if (psel_o && penable_o) begin
         accessCnt <= accessCnt + 1;
         if (paddr_o != setupAddr) addrStable <= 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                                input logic [BUS_WIDTH-1:0] wd, input logic [STRB_WIDTH-1:0] st,
                                input int tries, output logic acc);
      int n;
      @(negedge clk_i);
      cmd_write_i = wr;
      cmd_addr_i  = addr;
      cmd_wdata_i = wd;
      cmd_strb_i  = st;
      cmd_valid_i = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < tries) begin
         if (cmd_ready_o) begin
            @(posedge clk_i);
            acc = 1'b1;
         end else begin
            @(negedge clk_i);
            n++;
         end
      end
      #1 cmd_valid_i = 1'b0;
   endtask

   task automatic waitResponse(input string tag, input logic [63:0] expRdata, input logic expErr);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!rsp_valid_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput({tag, " rsp_valid"}, rsp_valid_o, 1);
      if (rsp_valid_o) begin
         checkOutput({tag, " rsp_rdata"}, rsp_rdata_o, expRdata);
         checkOutput({tag, " rsp_err"}, rsp_err_o, expErr);
         rsp_ready_i = 1'b1;
         @(posedge clk_i);
         #1 rsp_ready_i = 1'b0;
      end
   endtask

   // Watchdog against a hung simulation.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      logic acc;
      logic accList [4];
      int s0;

      #12;
      checkOutput("reset psel", psel_o, 0);
      checkOutput("reset penable", penable_o, 0);
      checkOutput("reset rsp_valid", rsp_valid_o, 0);
      checkOutput("reset busy", busy_o, 0);
      checkOutput("reset cmd_ready", cmd_ready_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      checkOutput("post-reset cmd_ready", cmd_ready_o, 1);

      $display("[TB] test 1: zero-wait write");
      s0 = setupCnt;
      rdData = 64'h1111_2222_3333_4444;
      applyStimulus(1'b1, 32'h0, 64'h0004_0003_0002_0001, 8'hFF, 5, acc);
      checkOutput("t1 accepted", acc, 1);
      @(posedge clk_i); #1;
      checkOutput("t1 setup psel", psel_o, 1);
      checkOutput("t1 setup penable", penable_o, 0);
      checkOutput("t1 paddr", paddr_o, 0);
      checkOutput("t1 pwrite", pwrite_o, 1);
      checkOutput("t1 pwdata", pwdata_o, 64'h0004_0003_0002_0001);
      checkOutput("t1 pstrb", pstrb_o, 8'hFF);
      @(posedge clk_i); #1;
      checkOutput("t1 access penable", penable_o, 1);
      checkOutput("t1 access psel", psel_o, 1);
      checkOutput("t1 early rsp_valid", rsp_valid_o, 0);
      @(posedge clk_i); #1;
      checkOutput("t1 rsp_valid at N+3", rsp_valid_o, 1);
      checkOutput("t1 psel dropped", psel_o, 0);
      checkOutput("t1 rsp_err", rsp_err_o, 0);
      checkOutput("t1 rsp_rdata", rsp_rdata_o, 0);
      checkOutput("t1 access cycles", accessCnt, 1);
      checkOutput("t1 setup count", setupCnt, s0 + 1);
      @(negedge clk_i);
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      checkOutput("t1 rsp consumed", rsp_valid_o, 0);
      checkOutput("t1 idle busy", busy_o, 0);

      $display("[TB] test 2: read with 5 wait states");
      waitStates = 5;
      rdData = 64'hDEAD_BEEF_0123_4567;
      applyStimulus(1'b0, 32'h10, 64'h5555_5555_5555_5555, 8'hFF, 5, acc);
      checkOutput("t2 accepted", acc, 1);
      waitResponse("t2", 64'hDEAD_BEEF_0123_4567, 1'b0);
      checkOutput("t2 access cycles", accessCnt, 6);
      checkOutput("t2 paddr stable", addrStable, 1);
      checkOutput("t2 paddr", setupAddr, 32'h10);
      checkOutput("t2 pstrb", setupStrb, 0);
      checkOutput("t2 pwrite", setupWrite, 0);
      waitStates = 0;

      $display("[TB] test 3: slave error then normal read");
      slvErr = 1'b1;
      applyStimulus(1'b1, 32'h20, 64'hABCD, 8'h0F, 5, acc);
      checkOutput("t3 accepted", acc, 1);
      waitResponse("t3 err", 64'h0, 1'b1);
      slvErr = 1'b0;
      rdData = 64'h0123_4567_89AB_CDEF;
      applyStimulus(1'b0, 32'h28, 64'h0, 8'h00, 5, acc);
      waitResponse("t3 next", 64'h0123_4567_89AB_CDEF, 1'b0);

      $display("[TB] test 4: backpressure with four pushes");
      s0 = setupCnt;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(4 * i), 64'(i + 1), 8'hFF, 4, accList[i]);
      end
      checkOutput("t4 push0", accList[0], 1);
      checkOutput("t4 push1", accList[1], 1);
      checkOutput("t4 push2", accList[2], 1);
      checkOutput("t4 push3 rejected", accList[3], 0);
      checkOutput("t4 cmd_ready full", cmd_ready_o, 0);
      repeat (10) @(negedge clk_i);
      checkOutput("t4 single issue", setupCnt, s0 + 1);
      checkOutput("t4 busy", busy_o, 1);
      for (int i = 0; i < 3; i++) begin
         waitResponse("t4", 64'h0, 1'b0);
      end
      repeat (3) @(negedge clk_i);
      checkOutput("t4 total issues", setupCnt, s0 + 3);
      checkOutput("t4 drained busy", busy_o, 0);

      $display("[TB] test 5: reset during ACCESS");
      waitStates = 1000;
      applyStimulus(1'b0, 32'h40, 64'h0, 8'h00, 5, acc);
      applyStimulus(1'b0, 32'h48, 64'h0, 8'h00, 5, acc);
      for (int i = 0; i < 20 && !(psel_o && penable_o); i++) @(negedge clk_i);
      checkOutput("t5 in access", psel_o & penable_o, 1);
      s0 = setupCnt;
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("t5 psel", psel_o, 0);
      checkOutput("t5 penable", penable_o, 0);
      checkOutput("t5 rsp_valid", rsp_valid_o, 0);
      checkOutput("t5 fifo empty busy", busy_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (20) @(negedge clk_i);
      checkOutput("t5 no response", rsp_valid_o, 0);
      checkOutput("t5 no issue", setupCnt, s0);
      checkOutput("t5 cmd_ready", cmd_ready_o, 1);
      waitStates = 0;

`ifdef MATMUL_APB_TIMEOUT_EN
      $display("[TB] test 6: ACCESS timeout");
      waitStates = 1000;
      rdData = 64'hCAFE_F00D_0000_0001;
      applyStimulus(1'b0, 32'h50, 64'h0, 8'h00, 5, acc);
      checkOutput("t6 accepted", acc, 1);
      waitResponse("t6", 64'h0, 1'b1);
      checkOutput("t6 access cycles", accessCnt, 8);
      waitStates = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
